// File: rtl/battle_phase_ctrl.sv
// Round-based encounter sequencer: menu, dodge, action, attack, check and result pages.
// Drives player instructions, the bullet engine and the attack-bar handshake from one tick-enabled phase timer.
//
// state  | meaning
// MENU   | title screen, SPACE starts a game once the lock time has passed
// DODGE  | bullets running, movement/hit instructions forwarded to the player
// ACTION | choice menu: J attack, K check, L spare
// ATTACK | attack bar running, waits for atk_pass or timeout
// CHECK  | inspect screen, J grants mercy once the lock time has passed
// WIN    | result screen, returns to MENU
// LOSE   | result screen, returns to MENU
module battle_phase_ctrl #(
  parameter int HP_W           = 8,
  parameter int MON_HP_MAX     = 100,
  parameter int PLAYER_HP_INIT = 100,
  parameter int HEAL_AMT       = 10,
  parameter int TW             = 4,
  parameter int MENU_LOCK      = 3,
  parameter int DODGE_TICKS    = 7,
  parameter int CHECK_LOCK     = 3,
  parameter int ATK_TIMEOUT    = 5,
  parameter int RESULT_TICKS   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [3:0]      key,
  input  logic            is_death,
  input  logic            hit_valid,
  input  logic            hit_heal,
  input  logic [7:0]      hit_dmg,
  input  logic            atk_pass,
  input  logic [HP_W-1:0] atk_dmg,
  output logic [7:0]      state,
  output logic [15:0]     player_instr,
  output logic            is_move,
  output logic            start_dmg,
  output logic [HP_W-1:0] mon_hp,
  output logic            mercy,
  output logic            atk_start,
  output logic            atk_button,
  output logic            atk_reset,
  output logic            bullet_run
);

  typedef enum logic [3:0] {
    PG_MENU   = 4'h1,
    PG_DODGE  = 4'h9,
    PG_ATTACK = 4'hA,
    PG_ACTION = 4'hB,
    PG_CHECK  = 4'hC,
    PG_WIN    = 4'hD,
    PG_LOSE   = 4'hE
  } page_t;

  localparam logic [3:0] K_NONE  = 4'd0;
  localparam logic [3:0] K_J     = 4'd5;
  localparam logic [3:0] K_K     = 4'd6;
  localparam logic [3:0] K_L     = 4'd7;
  localparam logic [3:0] K_SPACE = 4'd8;

  localparam logic [TW-1:0] TMR_MAX  = '1;
  localparam logic [HP_W:0] HP_SAT   = MON_HP_MAX[HP_W:0];
  localparam logic [7:0]    HP_INIT8 = PLAYER_HP_INIT[7:0];
  localparam logic [7:0]    HEAL8    = HEAL_AMT[7:0];

  page_t            page, page_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [3:0]       key_q;
  logic [31:0]      timer_w;
  logic             press;
  logic [3:0]       key_m1;
  logic [HP_W:0]    mon_sum;
  logic [HP_W-1:0]  mon_sat;

  logic [15:0]      instr_nxt;
  logic             is_move_nxt, start_dmg_nxt, mercy_nxt;
  logic             atk_start_nxt, atk_button_nxt, atk_reset_nxt, bullet_run_nxt;
  logic [HP_W-1:0]  mon_hp_nxt;

  assign timer_w = 32'(timer);
  assign press   = (key != K_NONE) && (key != key_q);
  assign key_m1  = key - 4'd1;
  // Sum is one bit wider than the accumulator so a large hit cannot wrap below the threshold.
  assign mon_sum = {1'b0, mon_hp} + {1'b0, atk_dmg};
  assign mon_sat = (mon_sum >= HP_SAT) ? HP_SAT[HP_W-1:0] : mon_sum[HP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page         <= PG_MENU;
      timer        <= '0;
      key_q        <= K_NONE;
      player_instr <= '0;
      is_move      <= 1'b0;
      start_dmg    <= 1'b0;
      mon_hp       <= '0;
      mercy        <= 1'b0;
      atk_start    <= 1'b0;
      atk_button   <= 1'b0;
      atk_reset    <= 1'b1;
      bullet_run   <= 1'b0;
    end else begin
      page         <= page_nxt;
      timer        <= timer_nxt;
      key_q        <= key;
      player_instr <= instr_nxt;
      is_move      <= is_move_nxt;
      start_dmg    <= start_dmg_nxt;
      mon_hp       <= mon_hp_nxt;
      mercy        <= mercy_nxt;
      atk_start    <= atk_start_nxt;
      atk_button   <= atk_button_nxt;
      atk_reset    <= atk_reset_nxt;
      bullet_run   <= bullet_run_nxt;
    end
  end

  assign state = {page, 4'b0000};

  // A page change clears the timer even if a tick lands in the same cycle.
  always_comb begin
    timer_nxt = timer;
    if (page_nxt != page)
      timer_nxt = '0;
    else if (tick && (timer != TMR_MAX))
      timer_nxt = timer + 1'b1;
  end

  always_comb begin
    page_nxt       = page;
    instr_nxt      = player_instr;
    is_move_nxt    = 1'b0;
    start_dmg_nxt  = 1'b0;
    mon_hp_nxt     = mon_hp;
    mercy_nxt      = mercy;
    atk_start_nxt  = atk_start;
    atk_button_nxt = atk_button;
    atk_reset_nxt  = atk_reset;
    bullet_run_nxt = bullet_run;

    case (page)
      PG_MENU: begin
        instr_nxt = '0;
        if (press && (key == K_SPACE) && (timer_w >= 32'(MENU_LOCK))) begin
          page_nxt       = PG_DODGE;
          mon_hp_nxt     = '0;
          mercy_nxt      = 1'b0;
          instr_nxt      = {4'd6, HP_INIT8, 4'd0};
          bullet_run_nxt = 1'b1;
          atk_reset_nxt  = 1'b1;
          atk_start_nxt  = 1'b0;
          atk_button_nxt = 1'b0;
        end
      end

      PG_DODGE: begin
        if (timer_w >= 32'(DODGE_TICKS)) begin
          page_nxt       = PG_ACTION;
          bullet_run_nxt = 1'b0;
          instr_nxt      = '0;
        end else if (is_death) begin
          page_nxt       = PG_LOSE;
          bullet_run_nxt = 1'b0;
        end else if (hit_valid) begin
          instr_nxt     = hit_heal ? {4'd1, HEAL8, 4'd0} : {4'd2, hit_dmg, 4'd0};
          start_dmg_nxt = 1'b1;
        end else if ((key != K_NONE) && (key <= 4'd4)) begin
          instr_nxt   = {4'd5, 6'd0, key_m1[1:0], 4'd0};
          is_move_nxt = 1'b1;
        end else begin
          instr_nxt = '0;
        end
      end

      PG_ACTION: begin
        if (press && (key == K_J)) begin
          page_nxt       = PG_ATTACK;
          atk_start_nxt  = 1'b1;
          atk_reset_nxt  = 1'b0;
          atk_button_nxt = 1'b0;
        end else if (press && (key == K_K)) begin
          page_nxt = PG_CHECK;
        end else if (press && (key == K_L)) begin
          if (mercy) begin
            page_nxt = PG_WIN;
          end else begin
            page_nxt       = PG_DODGE;
            bullet_run_nxt = 1'b1;
          end
        end
      end

      PG_CHECK: begin
        if (press && (timer_w >= 32'(CHECK_LOCK)) &&
            ((key == K_J) || (key == K_K) || (key == K_L))) begin
          if (key == K_J)
            mercy_nxt = 1'b1;
          page_nxt       = PG_DODGE;
          bullet_run_nxt = 1'b1;
        end
      end

      PG_ATTACK: begin
        if (press && (key == K_SPACE))
          atk_button_nxt = 1'b1;
        if (atk_pass) begin
          mon_hp_nxt    = mon_sat;
          atk_start_nxt = 1'b0;
          atk_reset_nxt = 1'b1;
          if (mon_sum >= HP_SAT) begin
            page_nxt = PG_WIN;
          end else begin
            page_nxt       = PG_DODGE;
            bullet_run_nxt = 1'b1;
          end
        end else if (timer_w >= 32'(ATK_TIMEOUT)) begin
          page_nxt       = PG_DODGE;
          bullet_run_nxt = 1'b1;
          atk_start_nxt  = 1'b0;
          atk_reset_nxt  = 1'b1;
        end
      end

      PG_WIN, PG_LOSE: begin
        bullet_run_nxt = 1'b0;
        instr_nxt      = '0;
        if (timer_w >= 32'(RESULT_TICKS))
          page_nxt = PG_MENU;
      end

      default: page_nxt = PG_MENU;
    endcase
  end

endmodule

// File: tb/tb_battle_phase_ctrl.sv
// Scoreboard bench for battle_phase_ctrl: directed encounter walk-through followed by random play,
// each cycle's expected outputs come from an integer-level model of the game rules.
module tb_battle_phase_ctrl;

  localparam int MENU_LOCK = 3, DODGE_TICKS = 7, CHECK_LOCK = 3, ATK_TIMEOUT = 5, RESULT_TICKS = 3;
  localparam int MON_MAX = 100;
  localparam int P_MENU = 1, P_DODGE = 9, P_ATTACK = 10, P_ACTION = 11, P_CHECK = 12, P_WIN = 13, P_LOSE = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [3:0]  key;
  logic        is_death, hit_valid, hit_heal;
  logic [7:0]  hit_dmg;
  logic        atk_pass;
  logic [7:0]  atk_dmg;
  logic [7:0]  state;
  logic [15:0] player_instr;
  logic        is_move, start_dmg;
  logic [7:0]  mon_hp;
  logic        mercy, atk_start, atk_button, atk_reset, bullet_run;

  battle_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key(key), .is_death(is_death),
    .hit_valid(hit_valid), .hit_heal(hit_heal), .hit_dmg(hit_dmg),
    .atk_pass(atk_pass), .atk_dmg(atk_dmg), .state(state), .player_instr(player_instr),
    .is_move(is_move), .start_dmg(start_dmg), .mon_hp(mon_hp), .mercy(mercy),
    .atk_start(atk_start), .atk_button(atk_button), .atk_reset(atk_reset), .bullet_run(bullet_run)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [38:0] exp_q[$];
  logic [38:0] act;

  assign act = {state, player_instr, is_move, start_dmg, mon_hp, mercy,
                atk_start, atk_button, atk_reset, bullet_run};

  // Game model state
  int          m_page, m_timer, m_keyq, m_mon;
  logic [15:0] m_instr;
  logic        m_mv, m_sd, m_mercy, m_as, m_ab, m_ar, m_br;

  task automatic model_reset();
    m_page = P_MENU; m_timer = 0; m_keyq = 0; m_mon = 0; m_instr = '0;
    m_mv = 0; m_sd = 0; m_mercy = 0; m_as = 0; m_ab = 0; m_ar = 1; m_br = 0;
  endtask

  function automatic logic [38:0] model_vec();
    logic [7:0] pg;
    logic [7:0] mh;
    pg = 8'(m_page * 16);
    mh = 8'(m_mon);
    return {pg, m_instr, m_mv, m_sd, mh, m_mercy, m_as, m_ab, m_ar, m_br};
  endfunction

  task automatic model_step();
    int np, k, sum;
    logic pr;
    k  = int'(key);
    pr = (k != 0) && (k != m_keyq);
    np = m_page;
    m_mv = 0;
    m_sd = 0;
    case (m_page)
      P_MENU: begin
        m_instr = '0;
        if (pr && k == 8 && m_timer >= MENU_LOCK) begin
          np = P_DODGE; m_mon = 0; m_mercy = 0; m_instr = 16'h6640;
          m_br = 1; m_ar = 1; m_as = 0; m_ab = 0;
        end
      end
      P_DODGE: begin
        if (m_timer >= DODGE_TICKS) begin
          np = P_ACTION; m_br = 0; m_instr = '0;
        end else if (is_death) begin
          np = P_LOSE; m_br = 0;
        end else if (hit_valid) begin
          m_instr = hit_heal ? 16'h10A0 : {4'h2, hit_dmg, 4'h0};
          m_sd = 1;
        end else if (k >= 1 && k <= 4) begin
          m_instr = 16'(16'h5000 + (k - 1) * 16);
          m_mv = 1;
        end else begin
          m_instr = '0;
        end
      end
      P_ACTION: begin
        if (pr && k == 5) begin
          np = P_ATTACK; m_as = 1; m_ar = 0; m_ab = 0;
        end else if (pr && k == 6) begin
          np = P_CHECK;
        end else if (pr && k == 7) begin
          if (m_mercy) np = P_WIN;
          else begin np = P_DODGE; m_br = 1; end
        end
      end
      P_CHECK: begin
        if (pr && m_timer >= CHECK_LOCK && k >= 5 && k <= 7) begin
          if (k == 5) m_mercy = 1;
          np = P_DODGE; m_br = 1;
        end
      end
      P_ATTACK: begin
        if (pr && k == 8) m_ab = 1;
        if (atk_pass) begin
          sum = m_mon + int'(atk_dmg);
          m_mon = (sum > MON_MAX) ? MON_MAX : sum;
          m_as = 0; m_ar = 1;
          if (sum >= MON_MAX) np = P_WIN;
          else begin np = P_DODGE; m_br = 1; end
        end else if (m_timer >= ATK_TIMEOUT) begin
          np = P_DODGE; m_br = 1; m_as = 0; m_ar = 1;
        end
      end
      P_WIN, P_LOSE: begin
        m_br = 0; m_instr = '0;
        if (m_timer >= RESULT_TICKS) np = P_MENU;
      end
      default: np = P_MENU;
    endcase
    if (np != m_page) m_timer = 0;
    else if (tick && m_timer < 15) m_timer = m_timer + 1;
    m_page = np;
    m_keyq = k;
  endtask

  // One clock: predict, queue the prediction, advance to just past the edge.
  task automatic cyc();
    model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #2;
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; cyc();
      tick = 0; cyc();
    end
  endtask

  task automatic press_key(input logic [3:0] k);
    key = k; cyc();
    key = 4'd0; cyc();
  endtask

  initial begin : monitor
    logic [38:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
        end
      end
    end
  end

  initial begin : driver
    logic [38:0] rst_vec;
    rst_vec = {8'h10, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst_n = 0; tick = 0; key = 0; is_death = 0; hit_valid = 0; hit_heal = 0;
    hit_dmg = 0; atk_pass = 0; atk_dmg = 0;
    model_reset();
    #23 rst_n = 1;
    cyc(); cyc();

    // Menu lock, start game
    tk(2); press_key(4'd8);
    tk(1); press_key(4'd8);
    // Dodge: movement, hit, then timeout to ACTION
    key = 4'd4; cyc(); cyc(); key = 4'd0;
    hit_valid = 1; hit_dmg = 8'd7; cyc(); hit_valid = 0;
    hit_valid = 1; hit_heal = 1; cyc(); hit_valid = 0; hit_heal = 0;
    cyc();
    tk(7);
    // Held J gives a single press
    key = 4'd5; repeat (10) cyc(); key = 4'd0;
    press_key(4'd8);
    atk_dmg = 8'd60; atk_pass = 1; cyc(); atk_pass = 0;
    tk(7); press_key(4'd5);
    atk_pass = 1; cyc(); atk_pass = 0;
    tk(3);
    // Attack timeout, then pass on the timeout cycle
    tk(3); press_key(4'd8);
    tk(7); press_key(4'd5); tk(5);
    tk(7); press_key(4'd5); tk(4);
    tick = 1; cyc(); tick = 0;
    atk_pass = 1; atk_dmg = 8'd30; cyc(); atk_pass = 0;
    // Check lock and mercy, then spare
    tk(7); press_key(4'd6);
    tk(1); press_key(4'd5);
    tk(2); press_key(4'd5);
    tk(7); press_key(4'd7);
    tk(3);
    // Death path
    tk(3); press_key(4'd8); cyc();
    is_death = 1; cyc(); is_death = 0;
    tk(3);
    // Asynchronous reset in ATTACK
    tk(3); press_key(4'd8); tk(7); press_key(4'd5); cyc();
    rst_n = 0;
    #1;
    checks++;
    if (act !== rst_vec) begin
      errors++;
      $display("FAIL async_reset actual=%h required=%h", act, rst_vec);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Random play
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0) key = 4'($urandom_range(8));
      hit_valid = ($urandom_range(7) == 0);
      hit_heal  = 1'($urandom_range(1));
      hit_dmg   = 8'($urandom_range(255));
      is_death  = ($urandom_range(99) == 0);
      atk_pass  = ($urandom_range(15) == 0);
      atk_dmg   = 8'($urandom_range(255));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/battle_phase_ctrl.md
Name: battle_phase_ctrl

Overview:
Parametrised successor to the battle-phase controller. Sequences a round-based encounter through MENU, DODGE, ACTION, ATTACK and CHECK, and adds WIN/LOSE result screens. Drives player instructions, the bullet engine and the attack-bar handshake. Adds key-press edge detection, saturating monster-HP arithmetic, a parametrised HP width, a single tick-enabled phase timer instead of a second clock domain, and an attack timeout.

Parameters:
HP_W, 8, width of monster HP accumulator and atk_dmg
MON_HP_MAX, 100, monster HP threshold for WIN; accumulator saturates here
PLAYER_HP_INIT, 100, 8-bit value carried in the set-HP instruction at game start
HEAL_AMT, 10, 8-bit heal amount in the heal instruction
TW, 4, phase-timer width; timer saturates at 2^TW-1
MENU_LOCK, 3, ticks in MENU before SPACE is accepted
DODGE_TICKS, 7, ticks spent in DODGE
CHECK_LOCK, 3, ticks in CHECK before J/K/L are accepted
ATK_TIMEOUT, 5, ticks in ATTACK before abort without damage
RESULT_TICKS, 3, ticks spent in WIN/LOSE before returning to MENU

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk pulse, nominally 1 Hz; enables the phase timer
key  in  4  decoded key: 0 none, 1 W, 2 A, 3 S, 4 D, 5 J, 6 K, 7 L, 8 SPACE
is_death  in  1  player HP reached zero
hit_valid  in  1  bullet collision resolved this cycle
hit_heal  in  1  the resolved hit is a heal item
hit_dmg  in  8  damage of the resolved hit
atk_pass  in  1  attack bar finished (one-cycle pulse)
atk_dmg  in  HP_W  damage dealt by the attack
state  out  8  {page[3:0], 4'b0}: MENU 1, DODGE 9, ATTACK A, ACTION B, CHECK C, WIN D, LOSE E
player_instr  out  16  {op[3:0], arg[7:0], 4'b0}: op 1 heal, 2 damage, 5 move, 6 set HP
is_move  out  1  movement instruction valid
start_dmg  out  1  one-cycle pulse: heal/damage instruction valid
mon_hp  out  HP_W  accumulated damage dealt to the monster
mercy  out  1  spare flag
atk_start, atk_button, atk_reset  out  1 each  attack-bar control
bullet_run  out  1  bullet engine enable

Behaviour:
- All outputs are registered. On reset: state=MENU, timer=0, key_q=0, atk_reset=1; every other output is 0.
- Press event: key!=0 and key!=key_q. key_q is registered every clk. All menu and choice actions use press events. Movement uses the key level.
- Phase timer: increments on tick and saturates at 2^TW-1. It clears on any state change. If a change and a tick occur in the same cycle, the clear wins.
- Default each cycle: start_dmg=0, is_move=0.
- Any page not listed above goes to MENU on the next clk.
- MENU:
  - player_instr=0.
  - SPACE press with timer>=MENU_LOCK goes to DODGE and sets mon_hp=0, mercy=0, player_instr={6,PLAYER_HP_INIT,0}, bullet_run=1, atk_reset=1, atk_start=0, atk_button=0.
- DODGE (priority order):
  1. timer>=DODGE_TICKS: go to ACTION; bullet_run=0; player_instr=0.
  2. is_death: go to LOSE; bullet_run=0.
  3. hit_valid: player_instr = hit_heal ? {1,HEAL_AMT,0} : {2,hit_dmg,0}; start_dmg=1.
  4. Otherwise: key W/A/S/D gives {5,dir,0} with dir 0/1/2/3 and is_move=1. Any other key gives player_instr=0.
- ACTION:
  - J press: go to ATTACK; atk_start=1, atk_reset=0, atk_button=0.
  - K press: go to CHECK.
  - L press: go to WIN if mercy=1; otherwise go to DODGE with bullet_run=1.
  - All other keys are ignored.
- CHECK:
  - Only when timer>=CHECK_LOCK: J press sets mercy=1 and goes to DODGE. K or L press goes to DODGE.
  - bullet_run=1 on any of these exits.
- ATTACK:
  - SPACE press sets atk_button=1. It stays 1 until the next ATTACK entry.
  - atk_pass:
    - mon_hp = min(mon_hp+atk_dmg, MON_HP_MAX), computed at HP_W+1 bits with no wrap.
    - If the result is >=MON_HP_MAX, go to WIN. Otherwise go to DODGE with bullet_run=1.
    - atk_start=0, atk_reset=1.
  - Timeout: timer>=ATK_TIMEOUT with no atk_pass goes to DODGE with bullet_run=1, atk_start=0, atk_reset=1; mon_hp is unchanged.
  - atk_pass and timeout in the same cycle: atk_pass wins.
- WIN/LOSE: bullet_run=0, player_instr=0. timer>=RESULT_TICKS goes to MENU.
- Reset mid-operation: asynchronous return to the reset values, with no completion pulse.

Test Plan:
- Reset, SPACE at 2 ticks: no move. SPACE again at 3 ticks -> state=0x90, player_instr=0x6640, bullet_run=1, mon_hp=0.
- DODGE, hold D -> player_instr=0x5030, is_move=1. hit_valid with hit_dmg=7 -> 0x2070, one start_dmg pulse. After 7 ticks -> state=0xB0, bullet_run=0.
- ACTION, J held for 10 clk -> a single transition to 0xA0, atk_start=1, atk_reset=0. SPACE -> atk_button=1. atk_pass with atk_dmg=60 twice across two rounds -> mon_hp saturates at 100, state=0xD0. After 3 ticks -> 0x10.
- ATTACK, no atk_pass for 5 ticks -> state=0x90, mon_hp unchanged, atk_reset=1. Repeat with atk_pass on the timeout cycle -> damage is applied.
- CHECK, J at 1 tick ignored; J at 3 ticks -> mercy=1, DODGE. Then ACTION with L -> WIN.
- is_death in DODGE -> 0xE0 -> MENU after 3 ticks. Also assert rst_n low mid-ATTACK -> all outputs at reset values immediately.
